// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Writer side of the instruction RAM. Parses a program image
//               arriving as a UART byte stream and writes 16-bit
//               instructions from address 0 upward. Holds the CPU in reset
//               while a frame is being loaded and reports done/error status.
//
//               Frame: SYNC_BYTE, COUNT_HI, COUNT_LO, COUNT x {HI, LO}
//               [, CHECKSUM when ROM_LOADER_CHECKSUM_EN is defined]
//
// Optional    : ROM_LOADER_CHECKSUM_EN - adds a trailing 8-bit checksum byte
//               (mod-256 sum of COUNT_HI, COUNT_LO and all data bytes).
//
// Ports       : i_CLK        system clock
//               i_Reset      synchronous active-high reset
//               i_Byte       received byte from UART RX
//               i_Byte_Valid one-cycle strobe qualifying i_Byte
//               o_Wr_En      one-cycle RAM write strobe
//               o_Wr_Addr    RAM write address
//               o_Wr_Data    RAM write data
//               o_CPU_Reset  high while a frame is being loaded
//               o_Busy       high in any state other than IDLE/DONE
//               o_Done       sticky: last frame loaded successfully
//               o_Error      sticky: last frame aborted
//
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int         DEPTH          = 2**15,
    parameter int         WIDTH          = 16,      // must be 16 (2 bytes/word)
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000  // >= 1
) (
    input  logic                     i_CLK,
    input  logic                     i_Reset,
    input  logic [7:0]               i_Byte,
    input  logic                     i_Byte_Valid,
    output logic                     o_Wr_En,
    output logic [$clog2(DEPTH)-1:0] o_Wr_Addr,
    output logic [WIDTH-1:0]         o_Wr_Data,
    output logic                     o_CPU_Reset,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Error
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_DONE    = 3'd5
`ifdef ROM_LOADER_CHECKSUM_EN
        , S_CHK   = 3'd6
`endif
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [15:0]          r_count;
    logic [c_ADDR_W:0]    r_addr;      // one extra bit so count == DEPTH never wraps
    logic [7:0]           r_hi;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 r_wr_en;
    logic [c_ADDR_W-1:0]  r_wr_addr;
    logic [WIDTH-1:0]     r_wr_data;
    logic                 r_done;
    logic                 r_error;

    logic                 w_in_frame;
    logic                 w_timeout;
    logic                 w_start;
    logic                 w_write;
    logic                 w_finish;
    logic                 w_fail;
    logic [15:0]          w_len;
    logic [c_ADDR_W:0]    w_addr_inc;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]           r_sum;
    // All frame bytes except SYNC and the checksum byte itself feed the sum.
    wire                  w_sum_byte = i_Byte_Valid &&
                                       (r_state == S_LEN_HI  || r_state == S_LEN_LO ||
                                        r_state == S_DATA_HI || r_state == S_DATA_LO);
    localparam state_t    c_END_STATE = S_CHK;
`else
    localparam state_t    c_END_STATE = S_DONE;
`endif

    assign w_in_frame = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_len      = {r_count[15:8], i_Byte};
    assign w_addr_inc = r_addr + 1'b1;
    // Fires on the TIMEOUT_CYCLES-th consecutive idle clock inside a frame.
    assign w_timeout  = w_in_frame && !i_Byte_Valid &&
                        (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_write  = 1'b0;
        w_finish = 1'b0;
        w_fail   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_Byte_Valid && i_Byte == SYNC_BYTE) begin
                    w_next  = S_LEN_HI;
                    w_start = 1'b1;
                end
            end
            S_LEN_HI: if (i_Byte_Valid) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (i_Byte_Valid) begin
                    if (w_len == 16'd0) begin
                        w_next = c_END_STATE;
                    end else if ({16'd0, w_len} > 32'(DEPTH)) begin
                        w_next = S_IDLE;
                        w_fail = 1'b1;
                    end else begin
                        w_next = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: if (i_Byte_Valid) w_next = S_DATA_LO;
            S_DATA_LO: begin
                if (i_Byte_Valid) begin
                    w_write = 1'b1;
                    if (32'(w_addr_inc) == 32'(r_count)) w_next = c_END_STATE;
                    else                                 w_next = S_DATA_HI;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (i_Byte_Valid) begin
                    if (i_Byte == r_sum) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_IDLE;
                        w_fail = 1'b1;
                    end
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
            w_fail = 1'b1;
        end
        if (w_next == S_DONE && r_state != S_DONE) w_finish = 1'b1;
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_addr    <= '0;
            r_hi      <= '0;
            r_timer   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_write;

            if (!w_in_frame || i_Byte_Valid) r_timer <= '0;
            else                             r_timer <= r_timer + 1'b1;

            if (i_Byte_Valid && r_state == S_LEN_HI)  r_count[15:8] <= i_Byte;
            if (i_Byte_Valid && r_state == S_LEN_LO)  r_count[7:0]  <= i_Byte;
            if (i_Byte_Valid && r_state == S_DATA_HI) r_hi          <= i_Byte;

            if (w_write) begin
                r_wr_addr <= r_addr[c_ADDR_W-1:0];
                r_wr_data <= {r_hi, i_Byte};
                r_addr    <= w_addr_inc;
            end

            if (w_start) begin
                r_addr  <= '0;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_finish) r_done  <= 1'b1;
            if (w_fail)   r_error <= 1'b1;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_CLK) begin
        if (i_Reset)         r_sum <= '0;
        else if (w_start)    r_sum <= '0;
        else if (w_sum_byte) r_sum <= r_sum + i_Byte;
    end
`endif

    assign o_Wr_En     = r_wr_en;
    assign o_Wr_Addr   = r_wr_addr;
    assign o_Wr_Data   = r_wr_data;
    assign o_Busy      = w_in_frame;
    assign o_CPU_Reset = w_in_frame;
    assign o_Done      = r_done;
    assign o_Error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_loader
// Description : Directed self-checking bench for rom_loader (DEPTH=16,
//               TIMEOUT_CYCLES=50). Honours ROM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    localparam int c_DEPTH   = 16;
    localparam int c_TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  r_byte = 8'h00;
    logic        r_valid = 1'b0;
    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [15:0] w_wr_data;
    logic        w_cpu_reset, w_busy, w_done, w_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  r_sum;
    logic [3:0]  log_addr[$];
    logic [15:0] log_data[$];

    always #5 clk = ~clk;

    rom_loader #(
        .DEPTH(c_DEPTH), .WIDTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .i_CLK(clk), .i_Reset(rst), .i_Byte(r_byte), .i_Byte_Valid(r_valid),
        .o_Wr_En(w_wr_en), .o_Wr_Addr(w_wr_addr), .o_Wr_Data(w_wr_data),
        .o_CPU_Reset(w_cpu_reset), .o_Busy(w_busy), .o_Done(w_done), .o_Error(w_error)
    );

    always @(negedge clk) if (w_wr_en) begin
        log_addr.push_back(w_wr_addr);
        log_data.push_back(w_wr_data);
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Byte is valid across exactly one posedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        r_byte  = b;
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
        r_sum   = r_sum + b;
    endtask

    task automatic send_sync();
        send_byte(8'hA5);
        r_sum = 8'h00;
    endtask

    // Trailing checksum byte, only present when the feature is compiled in.
    task automatic send_tail();
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(r_sum);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        n_checks++; if ({w_wr_en, w_wr_addr, w_wr_data} !== 21'd0) begin n_fail++; $display("FAIL reset_wr: got %b/%h/%h want 0/0/0", w_wr_en, w_wr_addr, w_wr_data); end
        n_checks++; if ({w_cpu_reset, w_busy, w_done, w_error} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {w_cpu_reset, w_busy, w_done, w_error}); end

        // Reset in the middle of a frame aborts it with no write.
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        n_checks++; if ({w_cpu_reset, w_busy} !== 2'b11) begin n_fail++; $display("FAIL midframe_busy: got %b want 11", {w_cpu_reset, w_busy}); end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        n_checks++; if ({w_wr_en, w_cpu_reset, w_busy, w_done, w_error} !== 5'b00000) begin n_fail++; $display("FAIL midframe_reset: got %b want 00000", {w_wr_en, w_cpu_reset, w_busy, w_done, w_error}); end
        n_checks++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL midframe_writes: got %0d want 0", log_addr.size()); end

        // Reset together with a SYNC byte: the byte is dropped.
        @(negedge clk);
        rst = 1'b1; r_byte = 8'hA5; r_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; r_valid = 1'b0;
        idle(1);
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset_vs_byte: busy got %b want 0", w_busy); end

        // A fresh frame after the aborted one loads normally.
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_tail();
        idle(2);
        n_checks++; if (log_addr.size() !== 1) begin n_fail++; $display("FAIL reload_count: got %0d want 1", log_addr.size()); end
        else begin
            n_checks++; if ({log_addr[0], log_data[0]} !== {4'd0, 16'hABCD}) begin n_fail++; $display("FAIL reload_word: got %h/%h want 0/abcd", log_addr[0], log_data[0]); end
        end
        n_checks++; if ({w_done, w_error} !== 2'b10) begin n_fail++; $display("FAIL reload_status: got %b want 10", {w_done, w_error}); end
    endtask

    task automatic test_normal_load();
        logic [7:0]  lo [3] = '{8'h10, 8'hFF, 8'h00};
        logic [7:0]  hi [3] = '{8'h00, 8'hFF, 8'h7F};
        clear_log();
        send_sync();
        n_checks++; if (w_cpu_reset !== 1'b1) begin n_fail++; $display("FAIL normal_cpu_reset: got %b want 1", w_cpu_reset); end
        send_byte(8'h00); send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            send_byte(hi[i]);
            n_checks++; if (w_wr_en !== 1'b0) begin n_fail++; $display("FAIL normal_no_early_wr[%0d]: got %b want 0", i, w_wr_en); end
            send_byte(lo[i]);
            // One clock after the accepting edge of the low byte.
            n_checks++; if ({w_wr_en, w_wr_addr, w_wr_data} !== {1'b1, 4'(i), hi[i], lo[i]}) begin n_fail++; $display("FAIL normal_write[%0d]: got %b/%h/%h want 1/%h/%h%h", i, w_wr_en, w_wr_addr, w_wr_data, i, hi[i], lo[i]); end
        end
`ifndef ROM_LOADER_CHECKSUM_EN
        n_checks++; if ({w_cpu_reset, w_busy, w_done} !== 3'b001) begin n_fail++; $display("FAIL normal_done_edge: got %b want 001", {w_cpu_reset, w_busy, w_done}); end
`endif
        send_tail();
        idle(2);
        n_checks++; if (log_addr.size() !== 3) begin n_fail++; $display("FAIL normal_count: got %0d want 3", log_addr.size()); end
        n_checks++; if ({w_wr_en, w_cpu_reset, w_busy, w_done, w_error} !== 5'b00010) begin n_fail++; $display("FAIL normal_status: got %b want 00010", {w_wr_en, w_cpu_reset, w_busy, w_done, w_error}); end
    endtask

    task automatic test_bad_count();
        clear_log();
        send_sync(); send_byte(8'h80); send_byte(8'h01);
        idle(2);
        n_checks++; if ({w_cpu_reset, w_busy, w_done, w_error} !== 4'b0001) begin n_fail++; $display("FAIL oversize_status: got %b want 0001", {w_cpu_reset, w_busy, w_done, w_error}); end
        // DEPTH+1 is the smallest oversize count.
        send_sync(); send_byte(8'h00); send_byte(8'h11);
        idle(2);
        n_checks++; if ({w_busy, w_error} !== 2'b01) begin n_fail++; $display("FAIL depth_plus1: got %b want 01", {w_busy, w_error}); end
        send_sync(); send_byte(8'h00); send_byte(8'h00); send_tail();
        idle(2);
        n_checks++; if ({w_busy, w_done, w_error} !== 3'b010) begin n_fail++; $display("FAIL zero_count: got %b want 010", {w_busy, w_done, w_error}); end
        n_checks++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL bad_count_writes: got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_timeout();
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        idle(c_TIMEOUT - 8);
        n_checks++; if ({w_busy, w_error} !== 2'b10) begin n_fail++; $display("FAIL timeout_early: got %b want 10", {w_busy, w_error}); end
        idle(16);
        n_checks++; if ({w_cpu_reset, w_busy, w_done, w_error} !== 4'b0001) begin n_fail++; $display("FAIL timeout_status: got %b want 0001", {w_cpu_reset, w_busy, w_done, w_error}); end
        n_checks++; if (log_addr.size() !== 1 || log_data[0] !== 16'h1122) begin n_fail++; $display("FAIL timeout_write: got %0d writes want 1 of 1122", log_addr.size()); end
        send_sync(); send_byte(8'h00); send_byte(8'h01); send_byte(8'h55); send_byte(8'h66); send_tail();
        idle(2);
        n_checks++; if ({w_done, w_error} !== 2'b10) begin n_fail++; $display("FAIL timeout_recover: got %b want 10", {w_done, w_error}); end
    endtask

    task automatic test_full_depth();
        logic [15:0] w;
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            w = (i % 2 == 0) ? {8'hA5, 8'(i)} : {8'(i * 3), 8'hA5};
            send_byte(w[15:8]); send_byte(w[7:0]);
        end
        send_tail();
        idle(2);
        n_checks++; if (log_addr.size() !== 16) begin n_fail++; $display("FAIL full_count: got %0d want 16", log_addr.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                w = (i % 2 == 0) ? {8'hA5, 8'(i)} : {8'(i * 3), 8'hA5};
                n_checks++; if ({log_addr[i], log_data[i]} !== {4'(i), w}) begin n_fail++; $display("FAIL full_word[%0d]: got %h/%h want %h/%h", i, log_addr[i], log_data[i], i, w); end
            end
        end
        n_checks++; if ({w_busy, w_done, w_error} !== 3'b010) begin n_fail++; $display("FAIL full_status: got %b want 010", {w_busy, w_done, w_error}); end
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        // Sum of 00 + 01 + 01 + 02 = 04.
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
        idle(2);
        n_checks++; if ({w_done, w_error} !== 2'b10) begin n_fail++; $display("FAIL chk_good: got %b want 10", {w_done, w_error}); end
        clear_log();
        send_sync(); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02); send_byte(8'h07);
        idle(2);
        n_checks++; if ({w_busy, w_done, w_error} !== 3'b001) begin n_fail++; $display("FAIL chk_bad: got %b want 001", {w_busy, w_done, w_error}); end
        n_checks++; if (log_addr.size() !== 1 || log_data[0] !== 16'h0102) begin n_fail++; $display("FAIL chk_bad_write: got %0d writes want 1 of 0102", log_addr.size()); end
    endtask
`endif

    initial begin
        r_sum = 8'h00;
        test_reset();
        test_normal_load();
        test_bad_count();
        test_timeout();
        test_full_depth();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
